// File: rtl/dense_layer_sequencer_if.sv
// Dense layer sequencer bus: start/status, the three synchronous-read memory
// ports (input, weight, bias) and the valid/ready result stream.
// master = sequencer side, slave = storage/downstream side.
interface dense_layer_sequencer_if #(
    parameter int IN_SIZE  = 128,
    parameter int OUT_SIZE = 64,
    parameter int IN_W     = 32,
    parameter int W_W      = 16,
    parameter int B_W      = 32,
    parameter int ACC_W    = 48
);
    localparam int IA_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int WA_W = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1;
    localparam int BA_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    logic              start;
    logic              busy;
    logic              done;
    logic [IA_W-1:0]   in_addr;
    logic [IN_W-1:0]   in_data;
    logic [WA_W-1:0]   w_addr;
    logic [W_W-1:0]    w_data;
    logic [BA_W-1:0]   b_addr;
    logic [B_W-1:0]    b_data;
    logic              out_valid;
    logic              out_ready;
    logic [BA_W-1:0]   out_idx;
    logic [ACC_W-1:0]  out_data;

    modport master (
        input  start, in_data, w_data, b_data, out_ready,
        output busy, done, in_addr, w_addr, b_addr, out_valid, out_idx, out_data
    );

    modport slave (
        output start, in_data, w_data, b_data, out_ready,
        input  busy, done, in_addr, w_addr, b_addr, out_valid, out_idx, out_data
    );
endinterface

// File: rtl/dense_layer_sequencer.sv
// Serial dense layer: one MAC walks every output neuron j, loads its bias,
// accumulates IN_SIZE input*weight products fetched from synchronous-read
// memories (data one cycle after address) and emits acc on a valid/ready stream.
// Optional build macro DENSE_SEQ_RELU_EN: clamps negative results to zero on
// the output only; the accumulator and the timing are unaffected.
module dense_layer_sequencer #(
    parameter int IN_SIZE  = 128,
    parameter int OUT_SIZE = 64,
    parameter int IN_W     = 32,
    parameter int W_W      = 16,
    parameter int B_W      = 32,
    parameter int ACC_W    = 48
) (
    input logic                  clk,
    input logic                  rst,
    dense_layer_sequencer_if.master bus
);
    localparam int IA_W   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int WA_W   = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1;
    localparam int BA_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int PROD_W = IN_W + W_W;

    localparam logic [IA_W-1:0] K_LAST = IA_W'(IN_SIZE - 1);
    localparam logic [BA_W-1:0] J_LAST = BA_W'(OUT_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [IA_W-1:0]         k;
    logic [BA_W-1:0]         j;
    logic [IA_W-1:0]         in_addr;
    logic [WA_W-1:0]         w_addr;
    logic [BA_W-1:0]         b_addr;
    logic signed [ACC_W-1:0] acc;
    logic                    busy;
    logic                    done;
    logic                    out_valid;
    logic [BA_W-1:0]         out_idx;
    logic signed [ACC_W-1:0] out_data;

    // Datapath: exact signed product, sign-extended into the accumulator width.
    // The first MAC cycle seeds with the bias instead of the running sum.
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_x;
    logic signed [ACC_W-1:0]  bias_x;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_nxt;

    assign prod     = PROD_W'($signed(bus.in_data)) * PROD_W'($signed(bus.w_data));
    assign prod_x   = ACC_W'(prod);
    assign bias_x   = ACC_W'($signed(bus.b_data));
    assign acc_base = (k == '0) ? bias_x : acc;
    assign acc_nxt  = acc_base + prod_x;

    // Output shaping; only the emitted value is clamped, never acc.
    function automatic logic signed [ACC_W-1:0] shape(input logic signed [ACC_W-1:0] a);
`ifdef DENSE_SEQ_RELU_EN
        return a[ACC_W-1] ? '0 : a;
`else
        return a;
`endif
    endfunction

    // Sequencer FSM with all outputs and memory addresses registered.
    // Addresses run one element ahead of the data in MAC and saturate at the
    // last element, so w_addr+1 out of EMIT lands on the next neuron's row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            k         <= '0;
            j         <= '0;
            in_addr   <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_BIAS;
                        busy    <= 1'b1;
                        j       <= '0;
                        b_addr  <= '0;
                        in_addr <= '0;
                        w_addr  <= '0;
                    end
                end
                S_BIAS: begin
                    state   <= S_MAC;
                    k       <= '0;
                    in_addr <= IA_W'(1);
                    w_addr  <= w_addr + WA_W'(1);
                end
                S_MAC: begin
                    acc <= acc_nxt;
                    if (in_addr != K_LAST) begin
                        in_addr <= in_addr + IA_W'(1);
                        w_addr  <= w_addr + WA_W'(1);
                    end
                    if (k == K_LAST) begin
                        state     <= S_EMIT;
                        out_valid <= 1'b1;
                        out_idx   <= j;
                        out_data  <= shape(acc_nxt);
                    end else begin
                        k <= k + IA_W'(1);
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (j == J_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_BIAS;
                            j       <= j + BA_W'(1);
                            b_addr  <= j + BA_W'(1);
                            in_addr <= '0;
                            w_addr  <= w_addr + WA_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    j       <= '0;
                    in_addr <= '0;
                    w_addr  <= '0;
                    b_addr  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.in_addr   = in_addr;
    assign bus.w_addr    = w_addr;
    assign bus.b_addr    = b_addr;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = out_idx;
    assign bus.out_data  = out_data;
endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Bench for dense_layer_sequencer: IN_SIZE=4, OUT_SIZE=3 main instance plus an
// OUT_SIZE=1 instance fed with extreme values to exercise accumulator wrap.
module tb_dense_layer_sequencer;
    localparam int IN_SIZE  = 4;
    localparam int OUT_SIZE = 3;
    localparam int IN_W     = 32;
    localparam int W_W      = 16;
    localparam int B_W      = 32;
    localparam int ACC_W    = 48;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dense_layer_sequencer_if #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .IN_W(IN_W),
        .W_W(W_W), .B_W(B_W), .ACC_W(ACC_W)) bus ();
    dense_layer_sequencer_if #(.IN_SIZE(IN_SIZE), .OUT_SIZE(1), .IN_W(IN_W),
        .W_W(W_W), .B_W(B_W), .ACC_W(ACC_W)) wbus ();

    dense_layer_sequencer #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .IN_W(IN_W),
        .W_W(W_W), .B_W(B_W), .ACC_W(ACC_W)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    dense_layer_sequencer #(.IN_SIZE(IN_SIZE), .OUT_SIZE(1), .IN_W(IN_W),
        .W_W(W_W), .B_W(B_W), .ACC_W(ACC_W)) u_wrap (.clk(clk), .rst(rst), .bus(wbus));

    // storage models: synchronous read, data one cycle after address
    logic signed [IN_W-1:0] in_mem [IN_SIZE];
    logic signed [W_W-1:0]  w_mem  [IN_SIZE*OUT_SIZE];
    logic signed [B_W-1:0]  b_mem  [OUT_SIZE];

    always @(posedge clk) begin
        bus.in_data  <= in_mem[bus.in_addr];
        bus.w_data   <= w_mem[bus.w_addr];
        bus.b_data   <= b_mem[bus.b_addr];
        wbus.in_data <= 32'h7FFF_FFFF;
        wbus.w_data  <= 16'h8000;
        wbus.b_data  <= '0;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
    endtask

    // reference: dot product + bias in wide integers, reduced mod 2^ACC_W
    function automatic logic [ACC_W-1:0] model_out(input int jj);
        longint s;
        logic [63:0] s64;
        logic [ACC_W-1:0] r;
        s = longint'(b_mem[jj]);
        for (int i = 0; i < IN_SIZE; i++)
            s += longint'(in_mem[i]) * longint'(w_mem[jj*IN_SIZE + i]);
        s64 = s;
        r = s64[ACC_W-1:0];
`ifdef DENSE_SEQ_RELU_EN
        if (r[ACC_W-1]) r = '0;
`endif
        return r;
    endfunction

    logic [ACC_W-1:0] exp_data [OUT_SIZE];
    logic [ACC_W-1:0] got_data [OUT_SIZE];
    logic [ACC_W-1:0] lit      [OUT_SIZE];

    // stream compare: every handshake against the model, stability while stalled,
    // and OUT_SIZE results per done pulse
    int               exp_idx = 0;
    int               n_out   = 0;
    int               n_done  = 0;
    logic             pv      = 1'b0;
    logic             phs     = 1'b0;
    logic [1:0]       pidx    = '0;
    logic [ACC_W-1:0] pdata   = '0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_idx = 0;
            pv      = 1'b0;
            phs     = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (pv && !phs) begin
                    check("hold_idx", 64'(bus.out_idx), 64'(pidx));
                    check("hold_data", 64'(bus.out_data), 64'(pdata));
                end
                if (bus.out_ready) begin
                    check("out_idx", 64'(bus.out_idx), 64'(exp_idx % OUT_SIZE));
                    check("out_data", 64'(bus.out_data), 64'(exp_data[exp_idx % OUT_SIZE]));
                    got_data[exp_idx % OUT_SIZE] = bus.out_data;
                    exp_idx++;
                    n_out++;
                end
            end
            if (bus.done) begin
                check("outs_per_pass", 64'(exp_idx), 64'(OUT_SIZE));
                exp_idx = 0;
                n_done++;
            end
            pv    = bus.out_valid;
            phs   = bus.out_valid && bus.out_ready;
            pidx  = bus.out_idx;
            pdata = bus.out_data;
        end
    end

    // Called at posedge+1 of cycle 0 (first BIAS cycle); counts to the done cycle.
    task automatic wait_done(input int exp_cyc, input int stall_idx, input int stall_n,
                             input int pulse_at, input bit hold, input string tag);
        int n = 0;
        int left = stall_n;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        while (!bus.done && n < 400) begin
            bus.start = hold || (n == pulse_at);
            if (left > 0 && bus.out_valid && int'(bus.out_idx) == stall_idx) begin
                bus.out_ready = 1'b0;
                left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        if (!hold) bus.start = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, "_done_cycle"}, 64'(n), 64'(exp_cyc));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_pass(input int exp_cyc, input int stall_idx, input int stall_n,
                            input int pulse_at, input string tag);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(exp_cyc, stall_idx, stall_n, pulse_at, 1'b0, tag);
    endtask

    task automatic check_results(input string tag);
        for (int jj = 0; jj < OUT_SIZE; jj++)
            check($sformatf("%s_lit%0d", tag, jj), 64'(got_data[jj]), 64'(lit[jj]));
    endtask

    task automatic clear_results();
        for (int jj = 0; jj < OUT_SIZE; jj++) got_data[jj] = '1;
    endtask

    initial begin
        int d0;
        int o0;
        int n;
        longint ws;
        logic [63:0] ws64;

        bus.start      = 1'b0;
        bus.out_ready  = 1'b1;
        wbus.start     = 1'b0;
        wbus.out_ready = 1'b1;
        in_mem = '{1, 2, 3, 4};
        w_mem  = '{1, 1, 1, 1, -1, 0, 0, 0, 2, -3, 0, 1};
        b_mem  = '{10, -5, 0};
        for (int jj = 0; jj < OUT_SIZE; jj++) exp_data[jj] = model_out(jj);
`ifdef DENSE_SEQ_RELU_EN
        lit = '{48'd20, 48'd0, 48'd0};
`else
        lit = '{48'd20, 48'(-6), 48'd0};
`endif
        for (int jj = 0; jj < OUT_SIZE; jj++)
            check($sformatf("model_n%0d", jj), 64'(exp_data[jj]), 64'(lit[jj]));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_idx", 64'(bus.out_idx), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_in_addr", 64'(bus.in_addr), 64'd0);
        check("rst_w_addr", 64'(bus.w_addr), 64'd0);
        check("rst_b_addr", 64'(bus.b_addr), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // nominal
        clear_results();
        run_pass(18, -1, 0, -1, "nom");
        check_results("nom");

        // backpressure on neuron 1 for 5 cycles
        clear_results();
        run_pass(23, 1, 5, -1, "bp");
        check_results("bp");

        // start pulsed mid-pass is ignored
        d0 = n_done;
        o0 = n_out;
        run_pass(18, -1, 0, 8, "pulse");
        repeat (20) @(posedge clk);
        #1;
        check("pulse_dones", 64'(n_done - d0), 64'd1);
        check("pulse_outs", 64'(n_out - o0), 64'd3);
        check("pulse_idle", 64'(bus.busy), 64'd0);

        // start held: back-to-back passes with one IDLE cycle between
        bus.start = 1'b1;
        @(posedge clk); #1;
        wait_done(18, -1, 0, -1, 1'b1, "hold1");
        @(posedge clk); #1;
        check("hold_restart", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done(18, -1, 0, -1, 1'b0, "hold2");

        // reset in MAC of neuron 1 (cycle 8), then rerun
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_results();
        run_pass(18, -1, 0, -1, "rerun");
        check_results("rerun");

        // accumulator wrap: 4 * (2^31-1) * (-2^15) mod 2^48 = 2^17
        ws = 0;
        for (int i = 0; i < IN_SIZE; i++) ws += longint'(32'sh7FFF_FFFF) * longint'(-32768);
        ws64 = ws;
        check("wrap_model", 64'(ws64[ACC_W-1:0]), 64'd131072);
        wbus.start = 1'b1;
        @(posedge clk); #1;
        wbus.start = 1'b0;
        n = 0;
        while (!wbus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("wrap_emit_cycle", 64'(n), 64'(IN_SIZE + 1));
        check("wrap_data", 64'(wbus.out_data), 64'(ws64[ACC_W-1:0]));
        check("wrap_idx", 64'(wbus.out_idx), 64'd0);
        @(posedge clk); #1;
        check("wrap_done", 64'(wbus.done), 64'd1);
        check("wrap_valid_drop", 64'(wbus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
